// File: rtl/alu_seq.sv
// Registered ALU with a barrel shifter on B, an iterative shift-add multiplier,
// valid/ready handshakes on both sides and a persistent NZCV flag register.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  input  logic [1:0]       bshift,
  input  logic [SHW-1:0]   shamt,
  input  logic             select,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic [3:0]       flags_q
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [3:0]       r_flags_q;
  logic             r_set_flags;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;

  // Each shift is widened by one bit so the bit shifted out lands in the carry slot.
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_bsh;
  logic             w_sh_c;

  assign w_lsl = {1'b0, b} << shamt;
  assign w_lsr = {b, 1'b0} >> shamt;
  assign w_asr = $signed({b, 1'b0}) >>> shamt;
  assign w_ror = WIDTH'({b, b, b} >> shamt);

  always_comb begin
    w_bsh  = b;
    w_sh_c = 1'b0;
    if (select && (shamt != '0)) begin
      case (bshift)
        2'b00:   {w_sh_c, w_bsh} = w_lsl;
        2'b01:   {w_bsh, w_sh_c} = w_lsr;
        2'b10:   {w_bsh, w_sh_c} = w_asr;
        default: begin
          w_bsh  = w_ror;
          w_sh_c = w_ror[WIDTH-1];
        end
      endcase
    end
  end

  logic             w_sub;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;

  assign w_sub = (ALUControl == OP_SUB) || (ALUControl == OP_CMP);
  assign w_bop = w_sub ? ~w_bsh : w_bsh;
  assign w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf = (a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    w_res = '0;
    w_c   = w_sh_c;
    w_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB, OP_CMP: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      OP_AND:  w_res = a & w_bsh;
      OP_ORR:  w_res = a | w_bsh;
      OP_EOR:  w_res = a ^ w_bsh;
      OP_MOV:  w_res = w_bsh;
      default: w_c = 1'b0;
    endcase
  end

  assign w_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

  logic [WIDTH-1:0] w_acc_next;
  logic             w_drain;
  logic             w_accept;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_drain    = r_out_valid && out_ready;
  // Held low while reset is asserted so nothing is accepted into a clearing pipeline.
  assign in_ready   = reset && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_flags_q   <= '0;
      r_set_flags <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_drain && r_set_flags) r_flags_q <= r_flags;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_set_flags <= set_flags;
            if (ALUControl == OP_MUL) begin
              r_mcand     <= a;
              r_mplier    <= w_bsh;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_state     <= S_MULT;
            end else begin
              r_result    <= w_res;
              r_flags     <= w_flags;
              r_out_valid <= 1'b1;
            end
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MULT: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + SHW'(1);
          if (r_cnt == LAST_STEP) begin
            r_result    <= w_acc_next;
            r_flags     <= {w_acc_next[WIDTH-1], (w_acc_next == '0), 2'b00};
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign Result    = r_result;
  assign ALUFlags  = r_flags;
  assign flags_q   = r_flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq at WIDTH=8 against an arithmetic
// reference model and a timing scoreboard of expected results.
module tb_alu_seq;
  localparam int W    = 8;
  localparam int SW   = 3;
  localparam int MOD  = 1 << W;
  localparam int MASK = MOD - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    ALUControl;
  logic [1:0]    bshift;
  logic [SW-1:0] shamt;
  logic          select;
  logic          set_flags;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic [3:0]    ALUFlags;
  logic [3:0]    flags_q;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(ALUControl), .bshift(bshift), .shamt(shamt),
    .select(select), .set_flags(set_flags), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .ALUFlags(ALUFlags), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         sf;
    logic         is_mul;
    int           avail;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         busy_until = 0;
  logic [3:0] fq_exp = 4'b0;
  logic       last_ov;
  logic       last_ir;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= MOD / 2) ? x - MOD : x;
  endfunction

  function automatic logic [W+3:0] ref_alu(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic [2:0] op, input logic [1:0] sh,
                                           input int amt, input logic sel);
    int ua, ub, bp, r, c, v, s;
    logic [W-1:0] rr;
    ua = int'(ra);
    ub = int'(rb);
    bp = ub;
    c  = 0;
    v  = 0;
    r  = 0;
    if (sel && amt != 0) begin
      case (sh)
        2'd0: begin s = ub << amt; bp = s & MASK; c = (s >> W) & 1; end
        2'd1: begin bp = ub >> amt; c = (ub >> (amt - 1)) & 1; end
        2'd2: begin s = sx(ub); bp = (s >>> amt) & MASK; c = (s >>> (amt - 1)) & 1; end
        default: begin
          bp = ((ub >> amt) | (ub << (W - amt))) & MASK;
          c  = (bp >> (W - 1)) & 1;
        end
      endcase
    end
    case (op)
      3'd0: begin
        s = ua + bp; r = s & MASK; c = (s >> W) & 1;
        s = sx(ua) + sx(bp); v = (s > MOD / 2 - 1 || s < -MOD / 2) ? 1 : 0;
      end
      3'd1, 3'd7: begin
        s = ua + (MASK - bp) + 1; r = s & MASK; c = (s >> W) & 1;
        s = sx(ua) - sx(bp); v = (s > MOD / 2 - 1 || s < -MOD / 2) ? 1 : 0;
      end
      3'd2: r = ua & bp;
      3'd3: r = ua | bp;
      3'd4: r = ua ^ bp;
      3'd5: r = bp;
      default: begin r = (ua * bp) & MASK; c = 0; v = 0; end
    endcase
    rr = W'(r);
    return {rr, rr[W-1], (rr == '0), c[0], v[0]};
  endfunction

  // One clock cycle: check DUT outputs against the scoreboard, then advance the model.
  task automatic cycle(output logic acc);
    logic exp_ov, exp_ir, drn;
    logic [W+3:0] r;
    exp_t e;
    #1;
    exp_ov = (q.size() > 0) && (q[0].avail <= cyc);
    exp_ir = reset && (cyc >= busy_until) && !(exp_ov && q[0].is_mul) && (!exp_ov || out_ready);
    last_ov = out_valid;
    last_ir = in_ready;
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("Result", Result, q[0].res);
      chk("ALUFlags", ALUFlags, q[0].fl);
    end
    chk("flags_q", flags_q, fq_exp);
    acc = in_valid && exp_ir;
    drn = exp_ov && out_ready;
    if (drn) begin
      if (q[0].sf) fq_exp = q[0].fl;
      void'(q.pop_front());
    end
    if (acc) begin
      r = ref_alu(a, b, ALUControl, bshift, int'(shamt), select);
      e.res    = r[W+3:4];
      e.fl     = r[3:0];
      e.sf     = set_flags;
      e.is_mul = (ALUControl == 3'd6);
      e.avail  = e.is_mul ? cyc + W + 1 : cyc + 1;
      if (e.is_mul) busy_until = cyc + W + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic [2:0] ctl,
                    input logic [1:0] sh, input logic [SW-1:0] amt, input logic sel,
                    input logic sf);
    logic acc;
    int k;
    a = oa; b = ob; ALUControl = ctl; bshift = sh; shamt = amt; select = sel; set_flags = sf;
    in_valid = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 40) begin
      cycle(acc);
      k++;
    end
    chk("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    logic acc;
    int n;
    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; ALUControl = '0; bshift = '0;
    shamt = '0; select = 1'b0; set_flags = 1'b0; out_ready = 1'b1;
    acc = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_Result", Result, 0);
    chk("rst_ALUFlags", ALUFlags, 0);
    in_valid = 1'b1;
    idle(2);
    in_valid = 1'b0;
    reset = 1'b1;
    idle(1);

    chk("ref_add", ref_alu(8'h7F, 8'h01, 3'd0, 2'd0, 0, 1'b0), {8'h80, 4'b1001});
    chk("ref_sub", ref_alu(8'h05, 8'h05, 3'd1, 2'd0, 0, 1'b0), {8'h00, 4'b0110});
    chk("ref_cmp", ref_alu(8'h03, 8'h04, 3'd7, 2'd0, 0, 1'b0), {8'hFF, 4'b1000});
    chk("ref_asr", ref_alu(8'h00, 8'h81, 3'd5, 2'd2, 1, 1'b1), {8'hC0, 4'b1010});
    chk("ref_ror", ref_alu(8'h00, 8'h81, 3'd5, 2'd3, 4, 1'b1), {8'h18, 4'b0000});
    chk("ref_lsl0", ref_alu(8'h00, 8'h81, 3'd5, 2'd0, 0, 1'b1), {8'h81, 4'b1000});
    chk("ref_mul", ref_alu(8'd13, 8'd11, 3'd6, 2'd0, 0, 1'b0), {8'h8F, 4'b1000});

    op(8'h7F, 8'h01, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    op(8'h05, 8'h05, 3'd1, 2'd0, 3'd0, 1'b0, 1'b1);
    op(8'h03, 8'h04, 3'd7, 2'd0, 3'd0, 1'b0, 1'b1);
    op(8'h00, 8'h81, 3'd5, 2'd2, 3'd1, 1'b1, 1'b0);
    op(8'h00, 8'h81, 3'd5, 2'd3, 3'd4, 1'b1, 1'b0);
    op(8'h00, 8'h81, 3'd5, 2'd0, 3'd0, 1'b1, 1'b1);
    idle(2);

    // Multiply with a competing request held on the input throughout.
    op(8'd13, 8'd11, 3'd6, 2'd0, 3'd0, 1'b0, 1'b1);
    a = 8'h11; b = 8'h22; ALUControl = 3'd0; in_valid = 1'b1;
    n = 0;
    do begin
      cycle(acc);
      n++;
    end while (!last_ov && n < 40);
    chk("mul_latency", n, W + 1);
    op(8'h11, 8'h22, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    idle(2);

    // Output stall, then a drain and a new accept in the same cycle.
    out_ready = 1'b0;
    op(8'h40, 8'h40, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    idle(5);
    out_ready = 1'b1;
    op(8'h03, 8'h04, 3'd7, 2'd0, 3'd0, 1'b0, 1'b1);
    chk("b2b_accept_with_drain", last_ov, 1);
    idle(2);

    // Reset in the middle of a multiply.
    op(8'd7, 8'd9, 3'd6, 2'd0, 3'd0, 1'b0, 1'b1);
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_flags_q", flags_q, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    q.delete();
    fq_exp = 4'b0;
    busy_until = 0;
    idle(2);
    reset = 1'b1;
    op(8'd2, 8'd2, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    chk("post_rst_add_latency", out_valid, 1);
    chk("post_rst_add_result", Result, 8'd4);
    idle(2);

    // Random traffic; a request not yet accepted is held unchanged.
    acc = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!in_valid || acc) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        a          = W'($urandom);
        b          = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
        ALUControl = 3'($urandom);
        bshift     = 2'($urandom);
        shamt      = SW'($urandom);
        select     = 1'($urandom);
        set_flags  = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(W + 4);
    chk("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
